pwm_demod: RTL and testbench

PWM_DEMOD -- requirements
Module: pwm_demod

---
 rtl/pwm_demod.sv | 128 ++++++++++++
 tb/tb_pwm_demod.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
// PWM demodulator: measures high time and period of an asynchronous PWM stream on the falling clock edge.
// Optional block averaging over 2^AvgK measurements is enabled by defining PWM_DEMOD_AVG_EN.
module pwm_demod #(
  parameter int unsigned CountN = 16,
  parameter int unsigned AvgK   = 2
) (
  input  logic              nReset,
  input  logic              Clk,
  input  logic              PWM,
  output logic [CountN-1:0] High,
  output logic [CountN-1:0] Period,
  output logic              Valid,
  output logic              Stuck,
  output logic              Level
);

  typedef enum logic {IDLE, MEASURE} state_e;

  localparam logic [CountN-1:0] CntOne     = CountN'(1);
  localparam logic [CountN-1:0] CntOnes    = '1;
  // Timeout fires on the clock the period counter would become all-ones.
  localparam logic [CountN-1:0] CntTimeout = ~CountN'(1);

  state_e            state_q;
  logic [2:0]        sync_q;
  logic              rise_q;
  logic [CountN-1:0] per_cnt_q;
  logic [CountN-1:0] high_cnt_q;
  logic [CountN-1:0] high_q;
  logic [CountN-1:0] period_q;
  logic              valid_q;
  logic              stuck_q;
  logic              level_q;

`ifdef PWM_DEMOD_AVG_EN
  localparam int unsigned AccW = CountN + AvgK;

  logic [AccW-1:0] acc_high_q;
  logic [AccW-1:0] acc_per_q;
  logic [AccW-1:0] acc_high_d;
  logic [AccW-1:0] acc_per_d;
  logic [AvgK-1:0] avg_cnt_q;

  assign acc_high_d = acc_high_q + AccW'(high_cnt_q);
  assign acc_per_d  = acc_per_q + AccW'(per_cnt_q);
`else
  logic unused_avg_k;
  assign unused_avg_k = (AvgK == 0);
`endif

  // sync_q[2] is the synchronized level, aligned with the registered rise strobe.
  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      rise_q     <= 1'b0;
      per_cnt_q  <= '0;
      high_cnt_q <= '0;
      high_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
      level_q    <= 1'b0;
`ifdef PWM_DEMOD_AVG_EN
      acc_high_q <= '0;
      acc_per_q  <= '0;
      avg_cnt_q  <= '0;
`endif
    end else begin
      sync_q    <= {sync_q[1:0], PWM};
      rise_q    <= sync_q[1] & ~sync_q[2];
      valid_q   <= 1'b0;
      per_cnt_q <= per_cnt_q + CntOne;
      if (state_q == MEASURE && sync_q[2]) begin
        high_cnt_q <= high_cnt_q + CntOne;
      end

      if (rise_q) begin
        state_q    <= MEASURE;
        per_cnt_q  <= CntOne;
        high_cnt_q <= CntOne;
        if (state_q == MEASURE) begin
          stuck_q <= 1'b0;
`ifdef PWM_DEMOD_AVG_EN
          if (avg_cnt_q == '1) begin
            high_q     <= acc_high_d[AccW-1:AvgK];
            period_q   <= acc_per_d[AccW-1:AvgK];
            valid_q    <= 1'b1;
            acc_high_q <= '0;
            acc_per_q  <= '0;
            avg_cnt_q  <= '0;
          end else begin
            acc_high_q <= acc_high_d;
            acc_per_q  <= acc_per_d;
            avg_cnt_q  <= avg_cnt_q + AvgK'(1);
          end
`else
          high_q   <= high_cnt_q;
          period_q <= per_cnt_q;
          valid_q  <= 1'b1;
`endif
        end
      end else if (per_cnt_q == CntTimeout) begin
        // Static input: report a stuck result and start over from IDLE.
        state_q    <= IDLE;
        per_cnt_q  <= '0;
        high_cnt_q <= '0;
        stuck_q    <= 1'b1;
        level_q    <= sync_q[2];
        high_q     <= {CountN{sync_q[2]}};
        period_q   <= CntOnes;
        valid_q    <= 1'b1;
`ifdef PWM_DEMOD_AVG_EN
        acc_high_q <= '0;
        acc_per_q  <= '0;
        avg_cnt_q  <= '0;
`endif
      end
    end
  end

  assign High   = high_q;
  assign Period = period_q;
  assign Valid  = valid_q;
  assign Stuck  = stuck_q;
  assign Level  = level_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod (CountN=8): timeouts, square-wave measurement, async reset, minimum period, averaging.
module tb_pwm_demod;

  localparam int unsigned CountN = 8;

  logic              Clk;
  logic              nReset;
  logic              PWM;
  logic [CountN-1:0] High;
  logic [CountN-1:0] Period;
  logic              Valid;
  logic              Stuck;
  logic              Level;

  int compared   = 0;
  int mismatched = 0;
  int tick_n     = 0;
  int base;
  int valid_count;
  int first_valid_tick;
  int last_valid_tick;
  int last_high;
  int last_period;
  int last_stuck;
  int sum_high;
  int sum_period;

  pwm_demod #(.CountN(CountN), .AvgK(2)) dut (
    .nReset (nReset),
    .Clk    (Clk),
    .PWM    (PWM),
    .High   (High),
    .Period (Period),
    .Valid  (Valid),
    .Stuck  (Stuck),
    .Level  (Level)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    base             = tick_n;
    valid_count      = 0;
    first_valid_tick = -1;
    last_valid_tick  = -1;
    last_high        = -1;
    last_period      = -1;
    last_stuck       = -1;
    sum_high         = 0;
    sum_period       = 0;
  endtask

  // One active (falling) edge; outputs are sampled 1 ns later and Valid results logged.
  task automatic tick();
    @(negedge Clk);
    #1;
    tick_n++;
    if (Valid === 1'b1) begin
      valid_count++;
      last_valid_tick = tick_n;
      if (first_valid_tick < 0) first_valid_tick = tick_n;
      last_high   = int'(High);
      last_period = int'(Period);
      last_stuck  = int'(Stuck);
      sum_high   += int'(High);
      sum_period += int'(Period);
    end
  endtask

  task automatic pwm_cycles(input int p, input int h, input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < p; i++) begin
        PWM = (i < h);
        tick();
      end
    end
  endtask

  initial begin
    nReset = 1'b0;
    PWM    = 1'b0;
    clear_stats();
    tick();
    tick();
    chk("reset_high", 32'(High), 0);
    chk("reset_period", 32'(Period), 0);
    chk("reset_valid", 32'(Valid), 0);
    chk("reset_stuck", 32'(Stuck), 0);
    chk("reset_level", 32'(Level), 0);

    // Input held low from reset: stuck report every 255 clocks.
    nReset = 1'b1;
    clear_stats();
    repeat (255) tick();
    chk("low_first_stuck_tick", 32'(first_valid_tick - base), 255);
    chk("low_stuck", 32'(Stuck), 1);
    chk("low_level", 32'(Level), 0);
    chk("low_high", 32'(High), 0);
    chk("low_period", 32'(Period), 255);
    tick();
    chk("low_valid_one_clock", 32'(Valid), 0);
    repeat (254) tick();
    chk("low_stuck_repeat_tick", 32'(last_valid_tick - base), 510);
    chk("low_stuck_count", 32'(valid_count), 2);

`ifndef PWM_DEMOD_AVG_EN
    // Square wave P=10 H=3: first Valid three edges after the second rising sample.
    clear_stats();
    pwm_cycles(10, 3, 4);
    chk("sq_first_valid_tick", 32'(first_valid_tick - base), 14);
    chk("sq_valid_count", 32'(valid_count), 3);
    chk("sq_high", 32'(last_high), 3);
    chk("sq_period", 32'(last_period), 10);
    chk("sq_stuck_cleared", 32'(last_stuck), 0);

    // Held high after valid results: one last measurement, then stuck high.
    clear_stats();
    PWM = 1'b1;
    repeat (270) tick();
    chk("hi_valid_count", 32'(valid_count), 2);
    chk("hi_stuck_tick", 32'(last_valid_tick - base), 258);
    chk("hi_stuck", 32'(Stuck), 1);
    chk("hi_level", 32'(Level), 1);
    chk("hi_high", 32'(High), 255);
    chk("hi_period", 32'(Period), 255);

    // Asynchronous reset in the middle of a period.
    clear_stats();
    PWM = 1'b0;
    repeat (5) tick();
    pwm_cycles(10, 3, 3);
    chk("pre_rst_valid_count", 32'(valid_count), 2);
    chk("pre_rst_high", 32'(High), 3);
    PWM = 1'b1;
    repeat (3) tick();
    PWM = 1'b0;
    repeat (2) tick();
    #2 nReset = 1'b0;
    #1;
    chk("async_rst_high", 32'(High), 0);
    chk("async_rst_period", 32'(Period), 0);
    chk("async_rst_level", 32'(Level), 0);
    chk("async_rst_valid", 32'(Valid), 0);
    tick();
    nReset = 1'b1;
    clear_stats();
    pwm_cycles(10, 3, 3);
    chk("post_rst_first_valid_tick", 32'(first_valid_tick - base), 14);
    chk("post_rst_valid_count", 32'(valid_count), 2);
    chk("post_rst_high", 32'(last_high), 3);
    chk("post_rst_period", 32'(last_period), 10);

    // Minimum measurable waveform P=2 H=1.
    pwm_cycles(2, 1, 3);
    clear_stats();
    pwm_cycles(2, 1, 7);
    chk("min_valid_count", 32'(valid_count), 7);
    chk("min_sum_high", 32'(sum_high), 7);
    chk("min_sum_period", 32'(sum_period), 14);
`endif

    // Periods 10,10,12,12 with highs 3,5,4,4 from a fresh reset.
    nReset = 1'b0;
    PWM    = 1'b0;
    tick();
    tick();
    nReset = 1'b1;
    clear_stats();
    pwm_cycles(10, 3, 1);
    pwm_cycles(10, 5, 1);
    pwm_cycles(12, 4, 2);
    PWM = 1'b1;
    repeat (5) tick();
`ifdef PWM_DEMOD_AVG_EN
    chk("avg_valid_count", 32'(valid_count), 1);
    chk("avg_valid_tick", 32'(last_valid_tick - base), 48);
    chk("avg_high", 32'(last_high), 4);
    chk("avg_period", 32'(last_period), 11);
`else
    chk("seq_valid_count", 32'(valid_count), 4);
    chk("seq_last_valid_tick", 32'(last_valid_tick - base), 48);
    chk("seq_sum_high", 32'(sum_high), 16);
    chk("seq_sum_period", 32'(sum_period), 44);
    chk("seq_last_high", 32'(last_high), 4);
    chk("seq_last_period", 32'(last_period), 12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
